// File: rtl/mem_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package mem_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  // Data-memory access controller states.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads the incoming instruction when enabled,
// otherwise loads a bubble (everything cleared, so valid and regwrite are 0).
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load_en,
  input  logic                 i_valid,
  input  logic                 i_regwrite,
  input  logic                 i_memreg,
  input  logic [REG_IDX_W-1:0] i_wr,
  input  logic [XLEN-1:0]      i_alu,
  input  logic [XLEN-1:0]      i_read_data,
  output logic                 o_valid,
  output logic                 o_regwrite,
  output logic                 o_memreg,
  output logic [REG_IDX_W-1:0] o_wr,
  output logic [XLEN-1:0]      o_alu,
  output logic [XLEN-1:0]      o_read_data
);

  logic                 r_valid;
  logic                 r_regwrite;
  logic                 r_memreg;
  logic [REG_IDX_W-1:0] r_wr;
  logic [XLEN-1:0]      r_alu;
  logic [XLEN-1:0]      r_read_data;

  // Capture the instruction, or insert a bubble while the stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memreg    <= 1'b0;
      r_wr        <= '0;
      r_alu       <= '0;
      r_read_data <= '0;
    end else if (i_load_en) begin
      r_valid     <= i_valid;
      r_regwrite  <= i_regwrite;
      r_memreg    <= i_memreg;
      r_wr        <= i_wr;
      r_alu       <= i_alu;
      r_read_data <= i_read_data;
    end else begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memreg    <= 1'b0;
      r_wr        <= '0;
      r_alu       <= '0;
      r_read_data <= '0;
    end
  end

  assign o_valid     = r_valid;
  assign o_regwrite  = r_regwrite;
  assign o_memreg    = r_memreg;
  assign o_wr        = r_wr;
  assign o_alu       = r_alu;
  assign o_read_data = r_read_data;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access FSM, stall generation, branch
// redirect and MEM/WB register. `reset` is asynchronous and active-low.
// Optional build macro MEM_TIMEOUT_EN adds an ack-wait watchdog that aborts
// an access after TIMEOUT_CYC cycles and pulses buserr_out.
//
// Data-memory handshake: dmem_req rises in the cycle after an aligned memory
// op is seen in IDLE and stays high, with dmem_addr/dmem_wdata/dmem_we
// stable, until the cycle in which dmem_ack is high; that cycle completes the
// transfer. dmem_ack is ignored whenever dmem_req is low.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      alu_in,
  input  logic [XLEN-1:0]      read_data2_in,
  input  logic [REG_IDX_W-1:0] wr_in,
  input  logic                 branch_in,
  input  logic                 zero_in,
  input  logic                 memread_in,
  input  logic                 memwrite_in,
  input  logic                 memreg_in,
  input  logic                 regwrite_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 stall_out,
  output logic                 pcsrc_out,
  output logic [XLEN-1:0]      branch_target_out,
  output logic                 valid_out,
  output logic                 regwrite_out,
  output logic                 memreg_out,
  output logic [REG_IDX_W-1:0] wr_out,
  output logic [XLEN-1:0]      read_data_out,
  output logic [XLEN-1:0]      alu_out,
  output logic                 misalign_out,
  output logic                 buserr_out,
  output state_e               dbg_state_out
);

  state_e          r_state;
  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_misalign;
  logic            r_buserr;

  logic            w_memacc;
  logic            w_memop;
  logic            w_misalign;
  logic            w_idle;
  logic            w_access;
  logic            w_ack;
  logic            w_timeout;
  logic            w_stall;
  logic            w_wb_regwrite;
  logic [XLEN-1:0] w_wb_read_data;

  assign w_idle     = (r_state == IDLE);
  assign w_access   = (r_state == ACCESS);
  assign w_memacc   = valid_in & (memread_in | memwrite_in);
  assign w_memop    = w_memacc & is_word_aligned(alu_in[1:0]);
  // Misalignment only matters when a new op is examined in IDLE.
  assign w_misalign = w_idle & w_memacc & ~is_word_aligned(alu_in[1:0]);
  assign w_ack      = w_access & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  // Last allowed ACCESS cycle passed with no ack.
  assign w_timeout = w_access & ~dmem_ack & (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count ACCESS cycles spent waiting for the ack; cleared otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_access & ~dmem_ack & ~w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout            = 1'b0;
`endif

  // Stall is combinational and forced low while reset is asserted.
  assign w_stall = reset & ((w_idle & w_memop) | (w_access & ~dmem_ack & ~w_timeout));

  // Access FSM: capture the request in IDLE, hold it until ack (or abort).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_memop) begin
            r_state <= ACCESS;
            r_req   <= 1'b1;
            r_we    <= memwrite_in;
            r_addr  <= alu_in;
            r_wdata <= read_data2_in;
          end
        end
        ACCESS: begin
          if (dmem_ack | w_timeout) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle fault pulses, aligned with the faulting write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
      r_buserr   <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
      r_buserr   <= w_timeout;
    end
  end

  // Faulted ops retire as valid but never write the register file.
  assign w_wb_regwrite  = regwrite_in & ~w_misalign & ~w_timeout;
  assign w_wb_read_data = (w_ack & ~r_we) ? dmem_rdata : '0;

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .rst_n       (reset),
    .i_load_en   (~w_stall),
    .i_valid     (valid_in),
    .i_regwrite  (w_wb_regwrite),
    .i_memreg    (memreg_in),
    .i_wr        (wr_in),
    .i_alu       (alu_in),
    .i_read_data (w_wb_read_data),
    .o_valid     (valid_out),
    .o_regwrite  (regwrite_out),
    .o_memreg    (memreg_out),
    .o_wr        (wr_out),
    .o_alu       (alu_out),
    .o_read_data (read_data_out)
  );

  assign dmem_req          = r_req;
  assign dmem_we           = r_we;
  assign dmem_addr         = r_addr;
  assign dmem_wdata        = r_wdata;
  assign stall_out         = w_stall;
  assign pcsrc_out         = reset & valid_in & branch_in & zero_in & ~w_stall;
  assign branch_target_out = reset ? pc_in : '0;
  assign misalign_out      = r_misalign;
  assign buserr_out        = r_buserr;
  assign dbg_state_out     = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios plus randomized
// instruction stream checked against a transaction-level model.
module tb_mem_access_stage;
  import mem_pkg::*;

  localparam int WB_W = 72;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pc_in, alu_in, read_data2_in;
  logic [4:0]  wr_in;
  logic        branch_in, zero_in, memread_in, memwrite_in, memreg_in, regwrite_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_out, pcsrc_out;
  logic [31:0] branch_target_out;
  logic        valid_out, regwrite_out, memreg_out;
  logic [4:0]  wr_out;
  logic [31:0] read_data_out, alu_out;
  logic        misalign_out, buserr_out;
  state_e      dbg_state_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [WB_W-1:0] exp_q[$];

  mem_access_stage #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .alu_in(alu_in),
    .read_data2_in(read_data2_in), .wr_in(wr_in), .branch_in(branch_in), .zero_in(zero_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in), .memreg_in(memreg_in),
    .regwrite_in(regwrite_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_out(stall_out), .pcsrc_out(pcsrc_out),
    .branch_target_out(branch_target_out), .valid_out(valid_out),
    .regwrite_out(regwrite_out), .memreg_out(memreg_out), .wr_out(wr_out),
    .read_data_out(read_data_out), .alu_out(alu_out), .misalign_out(misalign_out),
    .buserr_out(buserr_out), .dbg_state_out(dbg_state_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    valid_in = 0; pc_in = 0; alu_in = 0; read_data2_in = 0; wr_in = 0;
    branch_in = 0; zero_in = 0; memread_in = 0; memwrite_in = 0;
    memreg_in = 0; regwrite_in = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Drive one instruction in the EX/MEM slot until it retires. Called at
  // posedge+1. d = ACCESS cycles without ack before the acking cycle.
  task automatic run_instr(input logic v, input logic br, input logic zr,
                           input logic mr, input logic mw, input logic mreg,
                           input logic rw, input logic [31:0] pc,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wr, input int d,
                           input logic [31:0] rdata);
    logic is_mem, memop, mis, is_load, exp_stall;
    int len;
    logic [WB_W-1:0] exp_wb;
    is_mem  = v & (mr | mw);
    memop   = is_mem & (alu[1:0] == 2'b00);
    mis     = is_mem & (alu[1:0] != 2'b00);
    is_load = mr & ~mw;
    len     = memop ? d + 2 : 1;
    exp_q.push_back({v, rw & ~mis, mreg, wr, alu, (memop && is_load) ? rdata : 32'h0});
    valid_in = v; branch_in = br; zero_in = zr; memread_in = mr; memwrite_in = mw;
    memreg_in = mreg; regwrite_in = rw; pc_in = pc; alu_in = alu;
    read_data2_in = wd; wr_in = wr;
    for (int k = 0; k < len; k++) begin
      if (memop && k >= 1) begin
        dmem_ack   = (k == len - 1);
        dmem_rdata = (k == len - 1) ? rdata : $urandom;
      end else begin
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      exp_stall = memop && (k < len - 1);
      @(negedge clk);
      check_eq("stall", stall_out, exp_stall);
      check_eq("pcsrc", pcsrc_out, v & br & zr & ~exp_stall);
      check_eq("target", branch_target_out, pc);
      check_eq("req", dmem_req, memop && k >= 1);
      if (memop && k >= 1) begin
        check_eq("addr", dmem_addr, alu);
        check_eq("wdata", dmem_wdata, wd);
        check_eq("we", dmem_we, mw);
      end
      @(posedge clk); #1;
      if (k < len - 1) begin
        check_eq("bubble_valid", valid_out, 0);
        check_eq("bubble_regwrite", regwrite_out, 0);
      end
    end
    exp_wb = exp_q.pop_front();
    check_eq("wb_valid", valid_out, exp_wb[71]);
    check_eq("wb_regwrite", regwrite_out, exp_wb[70]);
    check_eq("wb_memreg", memreg_out, exp_wb[69]);
    check_eq("wb_wr", wr_out, exp_wb[68:64]);
    check_eq("wb_alu", alu_out, exp_wb[63:32]);
    check_eq("wb_rdata", read_data_out, exp_wb[31:0]);
    check_eq("misalign", misalign_out, mis);
    check_eq("buserr", buserr_out, 0);
    check_eq("state_idle", dbg_state_out, IDLE);
    dmem_ack = 0;
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    logic mr, mw;
    reset = 0;
    clear_inputs();
    // Inputs that would stall/redirect if reset did not gate them.
    valid_in = 1; branch_in = 1; zero_in = 1; memread_in = 1; pc_in = 32'h1234;
    #3;
    check_eq("rst_stall", stall_out, 0);
    check_eq("rst_pcsrc", pcsrc_out, 0);
    check_eq("rst_target", branch_target_out, 0);
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_alu", alu_out, 0);
    check_eq("rst_state", dbg_state_out, IDLE);
    repeat (2) @(negedge clk);
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;

    // ALU op
    run_instr(1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h10, 32'h0, 5'd3, 0, 32'h0);
    // Load from 0x100, ack on 2nd ACCESS cycle
    run_instr(1, 0, 0, 1, 0, 1, 1, 32'h0, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF);
    // Store to 0x104
    run_instr(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h104, 32'h55, 5'd0, 2, 32'hFFFF_FFFF);
    // Misaligned load
    run_instr(1, 0, 0, 1, 0, 1, 1, 32'h0, 32'h102, 32'h0, 5'd6, 0, 32'h0);
    // Taken branch
    run_instr(1, 1, 1, 0, 0, 0, 0, 32'h4000, 32'h0, 32'h0, 5'd0, 0, 32'h0);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 ACCESS cycles
    valid_in = 1; memread_in = 1; memreg_in = 1; regwrite_in = 1;
    alu_in = 32'h300; wr_in = 5'd7; dmem_ack = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("to_stall", stall_out, k < 4);
      check_eq("to_req", dmem_req, k >= 1);
      @(posedge clk); #1;
      if (k < 4) begin
        check_eq("to_bubble", valid_out, 0);
        check_eq("to_noerr", buserr_out, 0);
      end
    end
    check_eq("to_buserr", buserr_out, 1);
    check_eq("to_valid", valid_out, 1);
    check_eq("to_regwrite", regwrite_out, 0);
    check_eq("to_rdata", read_data_out, 0);
    check_eq("to_state", dbg_state_out, IDLE);
    clear_inputs();
    @(posedge clk); #1;
    check_eq("to_pulse_end", buserr_out, 0);
`else
    // Long wait: no watchdog, stage keeps stalling until the ack
    run_instr(1, 0, 0, 1, 0, 1, 1, 32'h0, 32'h208, 32'h0, 5'd9, 20, 32'hCAFE_F00D);
`endif

    // Reset during ACCESS, ack after release must be ignored
    valid_in = 1; memread_in = 1; regwrite_in = 1; alu_in = 32'h200; dmem_ack = 0;
    @(posedge clk); #1;
    check_eq("mr_req_up", dmem_req, 1);
    #2 reset = 0;
    #1;
    check_eq("mr_req_drop", dmem_req, 0);
    check_eq("mr_state", dbg_state_out, IDLE);
    check_eq("mr_stall", stall_out, 0);
    clear_inputs();
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    check_eq("mr_ack_req", dmem_req, 0);
    check_eq("mr_ack_stall", stall_out, 0);
    @(posedge clk); #1;
    check_eq("mr_ack_state", dbg_state_out, IDLE);
    check_eq("mr_ack_valid", valid_out, 0);
    check_eq("mr_ack_rdata", read_data_out, 0);
    dmem_ack = 0;

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      mr = 0; mw = 0;
      case (kind)
        1: begin mr = 1; a[1:0] = 2'b00; end
        2: begin mw = 1; mr = 1'($urandom_range(0, 1)); a[1:0] = 2'b00; end
        3: begin mr = 1'($urandom_range(0, 1)); mw = ~mr;
                 a[1:0] = 2'($urandom_range(1, 3)); end
        default: ;
      endcase
      run_instr(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), mr, mw, mr & ~mw,
                (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)),
                $urandom, a, $urandom, 5'($urandom_range(0, 31)),
                $urandom_range(0, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: maximum ack-wait cycles, used only with MEM_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port valid_in, input, 1: the EX/MEM register holds a live instruction.
REQ-005 SHALL have ports pc_in, alu_in, read_data2_in, input, 32 each: branch target, ALU result/address, store data.
REQ-006 SHALL have port wr_in, input, 5: destination register index.
REQ-007 SHALL have ports branch_in, zero_in, memread_in, memwrite_in, memreg_in, regwrite_in, input, 1 each: EX/MEM control.
REQ-008 SHALL have ports dmem_req, dmem_we, output, 1; dmem_addr, dmem_wdata, output, 32: data-memory request.
REQ-009 SHALL have ports dmem_ack, input, 1; dmem_rdata, input, 32: memory completion and load data.
REQ-010 SHALL have port stall_out, output, 1: freezes IF through EX/MEM while high.
REQ-011 SHALL have ports pcsrc_out, output, 1; branch_target_out, output, 32: taken-branch redirect.
REQ-012 SHALL have ports valid_out, regwrite_out, memreg_out, output, 1; wr_out, output, 5; read_data_out, alu_out, output, 32: MEM/WB register.
REQ-013 SHALL have ports misalign_out, buserr_out, output, 1: single-cycle fault pulses.

Function
REQ-014 SHALL use FSM states IDLE and ACCESS.
REQ-015 SHALL define memop = valid_in & (memread_in | memwrite_in) & (alu_in[1:0] == 0).
REQ-016 In IDLE with memop, SHALL capture address, wdata and we (we = memwrite_in; write wins if both set) and move to ACCESS.
REQ-017 In ACCESS, SHALL hold dmem_req=1 and drive the captured dmem_addr, dmem_wdata and dmem_we unchanged.
REQ-018 On dmem_ack in ACCESS, SHALL return to IDLE and load dmem_rdata into MEM/WB (load) or 0 (store).
REQ-019 SHALL drive stall_out = (IDLE & memop) | (ACCESS & ~dmem_ack), combinationally.
REQ-020 Latency: a memory op SHALL take at least 2 cycles with 1 stall cycle; a non-memory op SHALL take 1 cycle with no stall.
REQ-021 When stall_out=0, MEM/WB SHALL load valid_in, regwrite_in, memreg_in, wr_in and alu_in.
REQ-022 When stall_out=1, MEM/WB SHALL load a bubble (valid_out=0, regwrite_out=0).
REQ-023 SHALL drive pcsrc_out = valid_in & branch_in & zero_in & ~stall_out, and branch_target_out = pc_in.
REQ-024 On a misaligned memory op, SHALL issue no bus request and no stall, pulse misalign_out for 1 cycle, and write back with valid_out=1, regwrite_out=0.
REQ-025 SHALL ignore dmem_ack in IDLE; read_data_out SHALL be 0 for non-load instructions.

Reset
REQ-026 While reset=0, all outputs SHALL be 0, state SHALL be IDLE, and the counter SHALL be 0.
REQ-027 Reset mid-ACCESS SHALL drop dmem_req asynchronously; an ack arriving after release SHALL be ignored.

Configuration
REQ-028 With MEM_TIMEOUT_EN defined, an ACCESS cycle counter SHALL run; after TIMEOUT_CYC cycles without ack the stage SHALL abort to IDLE, pulse buserr_out for 1 cycle and write back with valid_out=1, regwrite_out=0.
REQ-029 Without MEM_TIMEOUT_EN, the stage SHALL wait for ack indefinitely, buserr_out SHALL be tied 0, and no counter SHALL exist.

Structure
REQ-030 Package mem_pkg SHALL hold the state enum, XLEN=32 and REG_IDX_W=5.
REQ-031 The MEM/WB register with bubble insertion SHALL be sub-module mem_wb_reg.

Verification
REQ-032 ALU op alu_in=0x10, regwrite_in=1, wr_in=3 -> next cycle alu_out=0x10, wr_out=3, valid_out=1, stall_out never high.
REQ-033 Load from 0x100, ack on 2nd ACCESS cycle with rdata=0xDEADBEEF -> stall_out high 2 cycles, then read_data_out=0xDEADBEEF, memreg_out=1.
REQ-034 Store to 0x104 with data 0x55 -> dmem_we=1, dmem_addr=0x104, dmem_wdata=0x55 held until ack; regwrite_out=0.
REQ-035 Load from address 0x102 -> misalign_out pulse, dmem_req stays 0, regwrite_out=0.
REQ-036 reset=0 during ACCESS, then ack 1 cycle after release -> dmem_req=0 immediately, ack ignored, state IDLE.
REQ-037 With MEM_TIMEOUT_EN and TIMEOUT_CYC=4, no ack -> buserr_out pulse after 4 ACCESS cycles, stall_out released.
